axis_nchan_lane_adder: RTL and testbench
========================================

// Module: axis_nchan_lane_adder
// PURPOSE
//  Parametrised successor to the fixed four-input stream adder. Joins NUM_CH AXI-Stream
//  inputs beat-for-beat and emits the lane-wise signed sum of their packed samples.
//  The output can be full precision or saturated back to the input sample width.
//  Sits between the per-channel capture streams and the S2MM DMA write path.
// PARAMETERS
//  NUM_CH    4   number of input streams (>=2)
//  LANES     8   signed samples per beat per stream
//  SAMPLE_W  16  input sample width in bits (two's complement)
//  SATURATE  0   0: OUT_W=SAMPLE_W+$clog2(NUM_CH), exact sum; 1: OUT_W=SAMPLE_W, clamp
// PORTS
//  CLK                   in   1                      clock
//  reset                 in   1                      async, active-high
//  s_axis_tdata          in   NUM_CH*LANES*SAMPLE_W  ch c, lane l at [(c*LANES+l)*SAMPLE_W +: SAMPLE_W]
//  s_axis_tvalid         in   NUM_CH                 per-channel valid
//  s_axis_tlast          in   NUM_CH                 per-channel last
//  s_axis_tready         out  NUM_CH                 per-channel ready (all bits identical)
//  m_axis_tdata          out  LANES*OUT_W            lane l at [l*OUT_W +: OUT_W]
//  m_axis_tvalid         out  1                      output valid
//  m_axis_tready         in   1                      downstream ready
//  m_axis_tlast          out  1                      channel-0 tlast of the summed beat
//  m_axis_tuser          out  1                      1 = at least one lane clamped (SATURATE=1 only)
//  frame_count           out  32                     count of output beats accepted with tlast=1
//  err_tlast_mismatch    out  1                      sticky: tlast bits disagreed on a joined beat
// BEHAVIOUR
//  - Reset (async assert, sync release): every output, pipeline valid, frame_count and
//    err_tlast_mismatch go to 0. In-flight beats are discarded. No partial beat is emitted.
//  - Two register stages, S1 then S2. Global enable ce = ~v2 | m_axis_tready.
//  - Join: all_v = &s_axis_tvalid. s_axis_tready[c] = all_v & ce for every c.
//    A beat is consumed only when all channels transfer in the same cycle.
//    No channel is ever consumed alone.
//  - When ce=1: v1 <= all_v. When a beat is consumed, S1 captures the full-precision sums.
//    Sums are sign-extended to SAMPLE_W+$clog2(NUM_CH) bits, so overflow is impossible.
//    S1 also captures tlast[0] and the mismatch flag (|tlast & ~&tlast).
//  - When ce=1: v2 <= v1 and S2 <= format(S1). When ce=0, S1 and S2 hold their contents.
//  - m_axis_tvalid = v2. Data, tlast and tuser stay stable while tvalid=1 and tready=0.
//  - Latency: 2 cycles from consumption to m_axis_tvalid with no stall.
//    Throughput: 1 beat/cycle while m_axis_tready=1.
//  - format, SATURATE=0: pass the exact sum through; m_axis_tuser stays 0.
//  - format, SATURATE=1:
//    > 2^(SAMPLE_W-1)-1        -> clamp to 2^(SAMPLE_W-1)-1
//    < -2^(SAMPLE_W-1)         -> clamp to -2^(SAMPLE_W-1)
//    m_axis_tuser = OR of the per-lane clamp flags.
//  - Partial valid (some channels valid, not all): no channel sees ready.
//    The valid channels hold their data. No state changes.
//  - Output stalled while the inputs are valid: ready stays 0 until ce=1.
//    No beat is dropped or duplicated.
//  - err_tlast_mismatch: set on the cycle an S1 beat with the mismatch flag is captured.
//    It stays set until reset. Data flow continues, and tlast follows channel 0.
//  - frame_count: increments on (m_axis_tvalid & m_axis_tready & m_axis_tlast).
//    It wraps from 2^32-1 to 0.
// TESTING
//  1. NUM_CH=4, SAMPLE_W=16, SATURATE=0. All lanes 16'h7FFF on all channels.
//     -> each output lane = 18'h1FFFC, 2 cycles after the join.
//  2. SATURATE=1. Lanes 30000 x4 and -30000 x4.
//     -> 16'h7FFF / 16'h8000, tuser=1. Lanes 1,2,3,4 -> 10, tuser=0.
//  3. Channels 0-2 valid, ch3 valid 5 cycles later.
//     -> s_axis_tready=0 for those 5 cycles; exactly one output beat.
//  4. Random m_axis_tready (50%) over 1000 beats with random data.
//     -> output matches the reference model in order, no loss or duplicate.
//     -> tdata is stable during stalls.
//  5. tlast={1,1,0,1} on beat 3 -> err_tlast_mismatch=1 from then on; m_axis_tlast=1.
//     Then 3 well-formed frames -> frame_count=4.
//  6. Reset asserted with 2 beats in flight.
//     -> m_axis_tvalid=0 immediately; the first output after release is the first new input.

Source files
------------

// File: rtl/axis_nchan_lane_adder_if.sv
`default_nettype none
// ============================================================================
//  Module      : axis_nchan_lane_adder_if
//  Description : AXI-Stream bundle with NCH parallel valid/last/ready bits.
//                Used for both the multi-channel input side and the
//                single-channel output side of the lane adder.
//  Revision    : 1.0  initial release
// ============================================================================
interface axis_nchan_lane_adder_if #(
  parameter int NCH = 1,
  parameter int DW  = 8
);
  logic [DW-1:0]  tdata;
  logic [NCH-1:0] tvalid;
  logic [NCH-1:0] tlast;
  logic [NCH-1:0] tready;
  logic           tuser;

  // Source side: drives the beat, observes ready
  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  // Sink side: observes the beat, drives ready (the input joiner has no use for tuser)
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/axis_nchan_lane_adder.sv
`default_nettype none
// ============================================================================
//  Module      : axis_nchan_lane_adder
//  Description : Joins NUM_CH AXI-Stream inputs beat-for-beat and emits the
//                lane-wise signed sum, either exact or clamped to SAMPLE_W.
//                Two register stages: S1 holds exact sums, S2 the formatted
//                output. Frame counter and sticky tlast-mismatch flag.
//  Revision    : 1.0  initial release
// ============================================================================
module axis_nchan_lane_adder #(
  parameter int NUM_CH   = 4,
  parameter int LANES    = 8,
  parameter int SAMPLE_W = 16,
  parameter int SATURATE = 0
) (
  input  wire logic                 CLK,
  input  wire logic                 reset,
  axis_nchan_lane_adder_if.slave    s_axis,
  axis_nchan_lane_adder_if.master   m_axis,
  output logic [31:0]               frame_count,
  output logic                      err_tlast_mismatch
);
  // Exact sums need log2(NUM_CH) guard bits so no lane can overflow
  localparam int SUM_W = SAMPLE_W + $clog2(NUM_CH);
  localparam int OUT_W = (SATURATE != 0) ? SAMPLE_W : SUM_W;

  logic                   w_all_v;
  logic                   w_ce;
  logic                   w_take;
  logic                   w_mis;
  logic [LANES*SUM_W-1:0] w_sum;
  logic [LANES*OUT_W-1:0] w_fmt;
  logic [LANES-1:0]       w_clip;

  logic                   r_v1;
  logic [LANES*SUM_W-1:0] r_s1_sum;
  logic                   r_s1_last;
  logic                   r_v2;
  logic [LANES*OUT_W-1:0] r_s2_data;
  logic                   r_s2_last;
  logic                   r_s2_user;
  logic [31:0]            r_frames;
  logic                   r_err;

  // The whole pipe advances together; a beat is consumed only when every channel is valid
  assign w_all_v       = &s_axis.tvalid;
  assign w_ce          = ~r_v2 | m_axis.tready[0];
  assign w_take        = w_all_v & w_ce;
  assign s_axis.tready = {NUM_CH{w_take}};
  assign w_mis         = (|s_axis.tlast) & ~(&s_axis.tlast);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [SUM_W-1:0] w_acc;
    logic signed [SUM_W-1:0] w_s1;

    // Sign-extended sum of this lane across all channels
    always_comb begin
      w_acc = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        w_acc = w_acc + SUM_W'($signed(s_axis.tdata[(c*LANES+l)*SAMPLE_W +: SAMPLE_W]));
      end
    end

    assign w_sum[l*SUM_W +: SUM_W] = w_acc;
    assign w_s1 = $signed(r_s1_sum[l*SUM_W +: SUM_W]);

    if (SATURATE != 0) begin : g_sat
      localparam logic signed [SUM_W-1:0] c_MAX = SUM_W'((64'sd1 <<< (SAMPLE_W-1)) - 64'sd1);
      localparam logic signed [SUM_W-1:0] c_MIN = -c_MAX - SUM_W'(1);
      logic [SAMPLE_W-1:0] w_lane;
      logic                w_c;

      // Clamp the exact S1 sum into the input sample range
      always_comb begin
        w_lane = w_s1[SAMPLE_W-1:0];
        w_c    = 1'b0;
        if (w_s1 > c_MAX) begin
          w_lane = c_MAX[SAMPLE_W-1:0];
          w_c    = 1'b1;
        end else if (w_s1 < c_MIN) begin
          w_lane = c_MIN[SAMPLE_W-1:0];
          w_c    = 1'b1;
        end
      end

      assign w_fmt[l*OUT_W +: OUT_W] = w_lane;
      assign w_clip[l]               = w_c;
    end else begin : g_full
      assign w_fmt[l*OUT_W +: OUT_W] = w_s1;
      assign w_clip[l]               = 1'b0;
    end
  end

  // Stage 1: capture exact sums and channel-0 tlast when the join fires
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_v1      <= 1'b0;
      r_s1_sum  <= '0;
      r_s1_last <= 1'b0;
    end else if (w_ce) begin
      r_v1 <= w_all_v;
      if (w_take) begin
        r_s1_sum  <= w_sum;
        r_s1_last <= s_axis.tlast[0];
      end
    end
  end

  // Stage 2: formatted output register, held while downstream stalls
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_v2      <= 1'b0;
      r_s2_data <= '0;
      r_s2_last <= 1'b0;
      r_s2_user <= 1'b0;
    end else if (w_ce) begin
      r_v2      <= r_v1;
      r_s2_data <= w_fmt;
      r_s2_last <= r_s1_last;
      r_s2_user <= |w_clip;
    end
  end

  // Sticky flag: channels disagreed on tlast for a joined beat
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_take && w_mis) begin
      r_err <= 1'b1;
    end
  end

  // Count frames leaving the block; wraps naturally at 2^32
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_frames <= '0;
    end else if (r_v2 && m_axis.tready[0] && r_s2_last) begin
      r_frames <= r_frames + 32'd1;
    end
  end

  assign m_axis.tdata       = r_s2_data;
  assign m_axis.tvalid      = r_v2;
  assign m_axis.tlast       = r_s2_last;
  assign m_axis.tuser       = r_s2_user;
  assign frame_count        = r_frames;
  assign err_tlast_mismatch = r_err;
endmodule
`default_nettype wire

// File: tb/tb_axis_nchan_lane_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_nchan_lane_adder
//  Description : Scoreboard bench. One exact-sum and one saturating instance
//                share the same input stream and downstream ready; expected
//                beats are computed with integer arithmetic and queued.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_axis_nchan_lane_adder;
  localparam int NCH = 4;
  localparam int LN  = 8;
  localparam int SW  = 16;
  localparam int FW  = 18;
  localparam int DW  = NCH*LN*SW;

  typedef struct {
    logic [LN*FW-1:0] full;
    logic [LN*SW-1:0] sat;
    logic             last;
    logic             user;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   out_cnt = 0;
  int   exp_frames = 0;
  int   rdy_mode = 0;   // 0: always ready, 1: random, 2: never ready

  logic        CLK = 1'b0;
  logic        reset;
  logic        m_rdy;
  logic [31:0] fc_a, fc_b;
  logic        err_a, err_b;

  always #5 CLK = ~CLK;

  axis_nchan_lane_adder_if #(.NCH(NCH), .DW(DW))    sa_if ();
  axis_nchan_lane_adder_if #(.NCH(NCH), .DW(DW))    sb_if ();
  axis_nchan_lane_adder_if #(.NCH(1),   .DW(LN*FW)) ma_if ();
  axis_nchan_lane_adder_if #(.NCH(1),   .DW(LN*SW)) mb_if ();

  assign sb_if.tdata  = sa_if.tdata;
  assign sb_if.tvalid = sa_if.tvalid;
  assign sb_if.tlast  = sa_if.tlast;
  assign ma_if.tready = m_rdy;
  assign mb_if.tready = m_rdy;

  axis_nchan_lane_adder #(.NUM_CH(NCH), .LANES(LN), .SAMPLE_W(SW), .SATURATE(0)) u_full (
    .CLK(CLK), .reset(reset), .s_axis(sa_if.slave), .m_axis(ma_if.master),
    .frame_count(fc_a), .err_tlast_mismatch(err_a));

  axis_nchan_lane_adder #(.NUM_CH(NCH), .LANES(LN), .SAMPLE_W(SW), .SATURATE(1)) u_sat (
    .CLK(CLK), .reset(reset), .s_axis(sb_if.slave), .m_axis(mb_if.master),
    .frame_count(fc_b), .err_tlast_mismatch(err_b));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer lane sums, then clamp for the saturating view
  function automatic exp_t model(input logic [DW-1:0] d, input logic [NCH-1:0] l);
    exp_t e;
    int s;
    logic signed [SW-1:0] x;
    logic [31:0] su;
    e.full = '0; e.sat = '0; e.user = 1'b0; e.last = l[0];
    for (int ln = 0; ln < LN; ln++) begin
      s = 0;
      for (int c = 0; c < NCH; c++) begin
        x = d[(c*LN+ln)*SW +: SW];
        s = s + int'(x);
      end
      su = s;
      e.full[ln*FW +: FW] = su[FW-1:0];
      if (s > 32767) begin
        e.sat[ln*SW +: SW] = 16'h7FFF; e.user = 1'b1;
      end else if (s < -32768) begin
        e.sat[ln*SW +: SW] = 16'h8000; e.user = 1'b1;
      end else begin
        e.sat[ln*SW +: SW] = su[SW-1:0];
      end
    end
    return e;
  endfunction

  function automatic logic [DW-1:0] fill(input logic [SW-1:0] v);
    logic [DW-1:0] r;
    for (int i = 0; i < NCH*LN; i++) r[i*SW +: SW] = v;
    return r;
  endfunction

  function automatic logic [DW-1:0] by_channel();
    logic [DW-1:0] r;
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < LN; i++) r[(c*LN+i)*SW +: SW] = SW'(c+1);
    return r;
  endfunction

  // Present one beat; channel 3 can lag by ch3_delay cycles. Returns after the join edge.
  task automatic send_beat(input logic [DW-1:0] d, input logic [NCH-1:0] l, input int ch3_delay);
    int t;
    @(negedge CLK);
    sa_if.tdata  = d;
    sa_if.tlast  = l;
    sa_if.tvalid = (ch3_delay > 0) ? 4'b0111 : 4'b1111;
    for (int k = 0; k < ch3_delay; k++) begin
      if (k > 0) @(negedge CLK);
      #1 check("partial_ready", 64'(sa_if.tready), 64'h0);
    end
    if (ch3_delay > 0) begin
      @(negedge CLK);
      sa_if.tvalid = 4'b1111;
    end
    #1;
    t = 0;
    while (sa_if.tready !== 4'hF && t < 200) begin
      @(negedge CLK);
      #1;
      t++;
    end
    if (t >= 200) begin
      check("join_timeout", 64'(sa_if.tready), 64'hF);
      sa_if.tvalid = '0;
      return;
    end
    q.push_back(model(d, l));
    if (l[0]) exp_frames++;
    @(posedge CLK);
  endtask

  task automatic drain();
    int t;
    @(negedge CLK);
    sa_if.tvalid = '0;
    t = 0;
    while (q.size() != 0 && t < 3000) begin
      @(negedge CLK);
      t++;
    end
    if (q.size() != 0) check("drain_timeout", 64'(q.size()), 64'h0);
    repeat (3) @(negedge CLK);
  endtask

  // Downstream ready generator
  initial begin
    m_rdy = 1'b1;
    forever begin
      @(negedge CLK);
      if (rdy_mode == 1)      m_rdy = 1'($urandom_range(0, 1));
      else if (rdy_mode == 2) m_rdy = 1'b0;
      else                    m_rdy = 1'b1;
    end
  end

  // Monitor: pop and compare on every output transfer; check hold during stalls
  initial begin
    logic [LN*FW-1:0] hold_a;
    logic [LN*SW-1:0] hold_b;
    logic             stalled;
    exp_t             e;
    stalled = 1'b0;
    forever begin
      @(negedge CLK);
      #2;
      if (reset) begin
        stalled = 1'b0;
      end else begin
        if (stalled && ma_if.tvalid[0]) begin
          checks++;
          if (ma_if.tdata !== hold_a || mb_if.tdata !== hold_b) begin
            failures++;
            $display("FAIL stall_hold actual=%h/%h expected=%h/%h", ma_if.tdata, mb_if.tdata, hold_a, hold_b);
          end
        end
        if (ma_if.tvalid[0] && m_rdy) begin
          out_cnt++;
          check("valid_pair", 64'(mb_if.tvalid), 64'h1);
          if (q.size() == 0) begin
            check("unexpected_beat", 64'(q.size()), 64'h1);
          end else begin
            e = q.pop_front();
            checks++;
            if (ma_if.tdata !== e.full) begin
              failures++;
              $display("FAIL out_full actual=%h expected=%h", ma_if.tdata, e.full);
            end
            checks++;
            if (mb_if.tdata !== e.sat) begin
              failures++;
              $display("FAIL out_sat actual=%h expected=%h", mb_if.tdata, e.sat);
            end
            check("tlast_full", 64'(ma_if.tlast), 64'(e.last));
            check("tlast_sat",  64'(mb_if.tlast), 64'(e.last));
            check("tuser_sat",  64'(mb_if.tuser), 64'(e.user));
            check("tuser_full", 64'(ma_if.tuser), 64'h0);
          end
          stalled = 1'b0;
        end else if (ma_if.tvalid[0]) begin
          stalled = 1'b1;
          hold_a  = ma_if.tdata;
          hold_b  = mb_if.tdata;
        end else begin
          stalled = 1'b0;
        end
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #600000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [DW-1:0] d;
    logic [NCH-1:0] l;
    int o0;
    sa_if.tdata  = '0;
    sa_if.tvalid = '0;
    sa_if.tlast  = '0;
    sa_if.tuser  = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge CLK);
    #3;
    check("rst_tvalid", 64'(ma_if.tvalid), 64'h0);
    check("rst_tvalid_sat", 64'(mb_if.tvalid), 64'h0);
    check("rst_frames", 64'(fc_a), 64'h0);
    check("rst_err", 64'(err_a), 64'h0);
    @(negedge CLK);
    reset = 1'b0;

    // Exact sum of full-scale positives, two-cycle latency
    send_beat(fill(16'h7FFF), 4'h0, 0);
    @(negedge CLK);
    sa_if.tvalid = '0;
    #3 check("lat_cycle1_valid", 64'(ma_if.tvalid), 64'h0);
    @(negedge CLK);
    #3 check("lat_cycle2_valid", 64'(ma_if.tvalid), 64'h1);
    check("lane0_1fffc", 64'(ma_if.tdata[FW-1:0]), 64'h1FFFC);
    check("lane7_1fffc", 64'(ma_if.tdata[7*FW +: FW]), 64'h1FFFC);
    drain();

    // Saturation both ways, then an in-range sum
    send_beat(fill(16'(30000)), 4'h0, 0);
    send_beat(fill(16'(-30000)), 4'h0, 0);
    send_beat(by_channel(), 4'h0, 0);
    drain();

    // Channel 3 arrives five cycles late: exactly one output beat
    o0 = out_cnt;
    send_beat(fill(16'h0123), 4'h0, 5);
    drain();
    check("late_ch3_one_beat", 64'(out_cnt - o0), 64'h1);

    // Inputs valid while output stalls: ready held low, nothing lost
    rdy_mode = 2;
    send_beat(fill(16'h0011), 4'h0, 0);
    send_beat(fill(16'h0022), 4'h0, 0);
    fork
      send_beat(fill(16'h0033), 4'h0, 0);
      begin
        repeat (5) begin
          @(negedge CLK);
          #1 check("stall_ready", 64'(sa_if.tready), 64'h0);
        end
        rdy_mode = 0;
      end
    join
    drain();

    // tlast mismatch on beat 3, then three well-formed frames
    send_beat(fill(16'h0001), 4'h0, 0);
    send_beat(fill(16'h0002), 4'h0, 0);
    @(negedge CLK);
    sa_if.tvalid = '0;
    #3 check("err_before", 64'(err_a), 64'h0);
    send_beat(fill(16'h0003), 4'b1101, 0);
    @(negedge CLK);
    sa_if.tvalid = '0;
    #3 check("err_set", 64'(err_a), 64'h1);
    check("err_set_sat", 64'(err_b), 64'h1);
    for (int f = 0; f < 3; f++) begin
      send_beat(fill(16'(f + 5)), 4'h0, 0);
      send_beat(fill(16'(f + 9)), 4'hF, 0);
    end
    drain();
    check("frames_4", 64'(fc_a), 64'd4);
    check("frames_4_sat", 64'(fc_b), 64'd4);
    check("err_sticky", 64'(err_a), 64'h1);

    // Reset with two beats in flight
    rdy_mode = 2;
    send_beat(fill(16'h0AAA), 4'hF, 0);
    send_beat(fill(16'h0BBB), 4'hF, 0);
    @(negedge CLK);
    sa_if.tvalid = '0;
    #4 reset = 1'b1;
    #1 check("rst_async_valid", 64'(ma_if.tvalid), 64'h0);
    check("rst_async_valid_sat", 64'(mb_if.tvalid), 64'h0);
    q.delete();
    exp_frames = 0;
    check("rst_frames_clr", 64'(fc_a), 64'h0);
    check("rst_err_clr", 64'(err_a), 64'h0);
    @(negedge CLK);
    @(negedge CLK);
    reset = 1'b0;
    rdy_mode = 0;
    o0 = out_cnt;
    send_beat(fill(16'h0C0C), 4'h0, 0);
    drain();
    check("post_rst_one_beat", 64'(out_cnt - o0), 64'h1);

    // Random data with random downstream ready
    rdy_mode = 1;
    o0 = out_cnt;
    for (int b = 0; b < 1000; b++) begin
      for (int i = 0; i < NCH*LN; i++) d[i*SW +: SW] = 16'($urandom);
      l = ($urandom_range(0, 3) == 0) ? 4'hF : 4'h0;
      send_beat(d, l, ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge CLK);
        sa_if.tvalid = '0;
        repeat ($urandom_range(0, 2)) @(negedge CLK);
      end
    end
    drain();
    check("random_beats", 64'(out_cnt - o0), 64'd1000);
    check("random_frames", 64'(fc_a), 64'(exp_frames));
    check("random_frames_sat", 64'(fc_b), 64'(exp_frames));
    check("random_err_clear", 64'(err_a), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
